mmult_arbiter: RTL and testbench
================================

MMULT_ARBITER -- requirements
Module: mmult_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, sets the RUN-state watchdog limit in clk cycles.
REQ-002 Parameter MAX_DIM, default 16, sets the largest legal matrix dimension.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req, input, 2 bits: per-requester job request, held high until the matching ack.
REQ-007 Port req_dims, input, 2x32 bits: per-requester {Ax,Ay,Bx,By}, 8 bits each.
REQ-008 Port ack, output, 2 bits: one-cycle job-complete pulse per requester.
REQ-009 Port err, output, 2 bits: asserted together with ack when the job was rejected or timed out.
REQ-010 Port mm_enable, output, 1 bit: multiplier enable, high throughout a job.
REQ-011 Port mm_sel, output, 1 bit: index of the granted requester, used for the operand and result mux.
REQ-012 Port mm_dims, output, 32 bits: latched {Ax,Ay,Bx,By} of the granted job.
REQ-013 Port mm_done, input, 1 bit: multiplier completion.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.
REQ-015 Port jobs_done, output, 16 bits: count of successfully completed jobs; wraps at 0xFFFF to 0.

Function
REQ-016 The state machine SHALL have the states IDLE, CHECK, RUN and RESP.
REQ-017 IDLE: if any req bit is high, the block SHALL grant one requester, latch its req_dims into mm_dims and set mm_sel; it moves to CHECK on the next edge.
REQ-018 Simultaneous requests SHALL be granted to the requester named by the round-robin pointer. The pointer resets to 0 and, in RESP, moves to the requester not just served.
REQ-019 CHECK lasts exactly one cycle. A job is valid only if every dimension is in 1..MAX_DIM and Ax equals By.
REQ-020 CHECK exit: a valid job goes to RUN; an invalid job goes to RESP with the error flag set, and mm_enable is never asserted.
REQ-021 RUN: mm_enable SHALL be high in every RUN cycle. When mm_done is sampled high at cycle T, the state is RESP at T+1 and mm_enable is low at T+1.
REQ-022 RESP lasts one cycle: ack[grant] is high; err[grant] is high if the error flag is set; otherwise jobs_done increments. The next state is IDLE.
REQ-023 Latency from a request seen in IDLE at cycle 0 to mm_enable high SHALL be 2 cycles.
REQ-024 mm_done SHALL be ignored outside RUN.
REQ-025 A req deasserted after grant SHALL NOT abort the job; ack still pulses.
REQ-026 req, req_dims and mm_dims changes after grant SHALL NOT affect the latched job.
REQ-027 A requester that still holds req in the cycle after its ack is treated as a new request, subject to round-robin.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE and set ack, err, mm_enable, mm_sel, mm_dims, busy, jobs_done, the pointer and the error flag to 0, including mid-RUN.
REQ-029 After reset is released, the first grant SHALL be evaluated at the first rising clk edge.

Configuration
REQ-030 With macro MMULT_ARB_TIMEOUT_EN defined, a counter SHALL count RUN cycles. When the count reaches TIMEOUT_CYCLES without mm_done, the block goes to RESP with the error flag set and drops mm_enable.
REQ-031 Without MMULT_ARB_TIMEOUT_EN, RUN SHALL wait for mm_done indefinitely, and no counter logic exists.

Structure
REQ-032 Package mmult_pkg SHALL hold the state enum, the dims struct {Ax,Ay,Bx,By} and the MAX_DIM default.
REQ-033 A sub-module rr_arbiter2 SHALL implement the two-way round-robin grant and pointer.
REQ-034 The FSM, dimension check and counters SHALL reside in mmult_arbiter.

Verification
REQ-035 req=01, dims {4,3,5,4}, mm_done pulsed 10 cycles after mm_enable rises -> mm_enable high from cycle 2, ack=01 with err=00, jobs_done=1.
REQ-036 req=11 with pointer at 0 -> requester 0 is served first, then requester 1 with no idle gap beyond the IDLE cycle; ack order is 01 then 10.
REQ-037 dims {4,3,5,6} (Ax≠By) or any dimension 0 or 17 -> ack and err pulse on cycle 2, mm_enable never high, jobs_done unchanged.
REQ-038 With MMULT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8 and no mm_done -> mm_enable high for exactly 8 cycles, then ack and err pulse.
REQ-039 reset asserted mid-RUN between edges -> mm_enable, busy and jobs_done are 0 immediately; after release the pending req is regranted to requester 0.
REQ-040 A stray mm_done pulse in IDLE followed by a new job -> the job still waits for its own mm_done.

Source files
------------

// File: rtl/mmult_pkg.sv
// mmult_pkg: shared types and defaults for the matrix-multiply job arbiter.
//   state_t         - arbiter FSM states (IDLE, CHECK, RUN, RESP)
//   dims_t          - packed job dimensions {ax, ay, bx, by}, 8 bits each
//   MAX_DIM_DEFAULT - default largest legal matrix dimension
//   dim_ok()        - range check of one dimension against 1..max_dim
package mmult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RUN,
        RESP
    } state_t;

    typedef struct packed {
        logic [7:0] ax;
        logic [7:0] ay;
        logic [7:0] bx;
        logic [7:0] by;
    } dims_t;

    localparam int unsigned MAX_DIM_DEFAULT = 16;

    function automatic logic dim_ok(input logic [7:0] d, input int unsigned max_dim);
        return (d != 8'd0) && ({24'd0, d} <= max_dim);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with a one-bit priority pointer.
//   clk, reset  - clock, asynchronous active-low reset (pointer -> 0)
//   req[1:0]    - request vector
//   update      - advance the pointer away from 'served' at this edge
//   served      - index of the requester just served
//   gnt_idx     - index of the requester that wins this cycle
//   gnt_any     - at least one request is pending
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       gnt_idx,
    output logic       gnt_any
);

    logic ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= 1'b0;
        else if (update)
            ptr <= ~served;
    end

    // Pointer only breaks ties; a lone request always wins.
    always_comb begin
        gnt_any = |req;
        gnt_idx = req[1];
        if (req == 2'b11)
            gnt_idx = ptr;
    end

endmodule

// File: rtl/mmult_arbiter.sv
// mmult_arbiter: arbitrates two requesters onto one matrix multiplier.
// Grants a job in IDLE, validates its dimensions in CHECK, enables the
// multiplier in RUN until mm_done, and pulses ack (plus err on rejection
// or timeout) in RESP.
//   clk, reset     - clock, asynchronous active-low reset
//   req[1:0]       - per-requester job request, held until ack
//   req_dims[1:0]  - per-requester {Ax,Ay,Bx,By}
//   ack[1:0]       - one-cycle job-complete pulse
//   err[1:0]       - with ack when the job was rejected or timed out
//   mm_enable      - multiplier enable during RUN
//   mm_sel         - granted requester index
//   mm_dims        - latched dimensions of the granted job
//   mm_done        - multiplier completion (ignored outside RUN)
//   busy           - high whenever not IDLE
//   jobs_done      - count of successful jobs, wraps at 0xFFFF
// Optional feature: define MMULT_ARB_TIMEOUT_EN to add a RUN watchdog of
// TIMEOUT_CYCLES cycles.
module mmult_arbiter
    import mmult_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned MAX_DIM        = MAX_DIM_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0][31:0] req_dims,
    output logic [1:0]       ack,
    output logic [1:0]       err,
    output logic             mm_enable,
    output logic             mm_sel,
    output logic [31:0]      mm_dims,
    input  logic             mm_done,
    output logic             busy,
    output logic [15:0]      jobs_done
);

    state_t      state, state_nxt;
    logic        sel;
    dims_t       dims;
    logic        err_flag;
    logic [15:0] jobs_cnt;
    logic        gnt_idx, gnt_any;
    logic        job_ok;
    logic        timeout;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .update  (state == RESP),
        .served  (sel),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign job_ok = dim_ok(dims.ax, MAX_DIM) && dim_ok(dims.ay, MAX_DIM) &&
                    dim_ok(dims.bx, MAX_DIM) && dim_ok(dims.by, MAX_DIM) &&
                    (dims.ax == dims.by);

`ifdef MMULT_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            run_cnt <= '0;
        else if (state != RUN)
            run_cnt <= '0;
        else
            run_cnt <= run_cnt + CW'(1);
    end

    // Fires in the last allowed RUN cycle so RUN lasts exactly TIMEOUT_CYCLES.
    assign timeout = (state == RUN) && (run_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sel      <= 1'b0;
            dims     <= '0;
            err_flag <= 1'b0;
            jobs_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        sel      <= gnt_idx;
                        dims     <= req_dims[gnt_idx];
                        err_flag <= 1'b0;
                    end
                end
                CHECK: begin
                    if (!job_ok)
                        err_flag <= 1'b1;
                end
                RUN: begin
                    // A completion in the final watchdog cycle still counts as success.
                    if (!mm_done && timeout)
                        err_flag <= 1'b1;
                end
                RESP: begin
                    if (!err_flag)
                        jobs_cnt <= jobs_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        mm_enable = 1'b0;
        busy      = 1'b1;
        ack       = '0;
        err       = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (gnt_any)
                    state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = job_ok ? RUN : RESP;
            end
            RUN: begin
                mm_enable = 1'b1;
                if (mm_done || timeout)
                    state_nxt = RESP;
            end
            RESP: begin
                ack       = {sel, ~sel};
                err       = err_flag ? {sel, ~sel} : 2'b00;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mm_sel    = sel;
    assign mm_dims   = dims;
    assign jobs_done = jobs_cnt;

endmodule

// File: tb/tb_mmult_arbiter.sv
// tb_mmult_arbiter: directed scoreboard bench for mmult_arbiter.
// Stimulus pushes the expected ack/err/sel/dims of each job into a queue;
// a monitor pops and compares whenever ack is presented.
module tb_mmult_arbiter;

`ifdef MMULT_ARB_TIMEOUT_EN
    localparam int unsigned TO       = 8;
    localparam int          LONG_DLY = 6;
`else
    localparam int unsigned TO       = 4096;
    localparam int          LONG_DLY = 10;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       req = '0;
    logic [1:0][31:0] req_dims = '0;
    logic [1:0]       ack, err;
    logic             mm_enable, mm_sel;
    logic [31:0]      mm_dims;
    logic             mm_done = 1'b0;
    logic             busy;
    logic [15:0]      jobs_done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic        sel;
        logic [31:0] dims;
    } exp_t;

    exp_t sbq[$];

    mmult_arbiter #(.TIMEOUT_CYCLES(TO), .MAX_DIM(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_dims  (req_dims),
        .ack       (ack),
        .err       (err),
        .mm_enable (mm_enable),
        .mm_sel    (mm_sel),
        .mm_dims   (mm_dims),
        .mm_done   (mm_done),
        .busy      (busy),
        .jobs_done (jobs_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic idx, input logic [31:0] d, input bit e);
        exp_t x;
        x.ack  = idx ? 2'b10 : 2'b01;
        x.err  = e ? x.ack : 2'b00;
        x.sel  = idx;
        x.dims = d;
        sbq.push_back(x);
    endtask

    // Monitor: every ack pulse must match the oldest outstanding job.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ack", {30'd0, ack}, 32'd0);
                end else begin
                    x = sbq.pop_front();
                    check("sb_ack", {30'd0, ack}, {30'd0, x.ack});
                    check("sb_err", {30'd0, err}, {30'd0, x.err});
                    check("sb_sel", {31'd0, mm_sel}, {31'd0, x.sel});
                    check("sb_dims", mm_dims, x.dims);
                    check("sb_enable_low_in_resp", {31'd0, mm_enable}, 32'd0);
                end
            end
        end
    end

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (mm_enable === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_enable_expired", 32'd0, 32'd1);
    endtask

    // Returns at the negedge showing ack[idx] (possibly the current one), then drops req[idx].
    task automatic wait_ack(input logic idx);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (ack[idx] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("wait_ack_expired", 32'd0, 32'd1);
        req[idx] = 1'b0;
    endtask

    // Called at the negedge where mm_enable was first seen; n RUN cycles total.
    task automatic run_for(input int n);
        bit all_hi;
        all_hi = 1'b1;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            if (mm_enable !== 1'b1 || ack !== 2'b00) all_hi = 1'b0;
        end
        check("enable_held_in_run", {31'd0, all_hi}, 32'd1);
        mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
        check("enable_low_after_done", {31'd0, mm_enable}, 32'd0);
    endtask

    task automatic bad_job(input logic idx, input logic [31:0] d, input string nm,
                           input logic [15:0] jobs_exp);
        req_dims[idx] = d;
        req[idx]      = 1'b1;
        push(idx, d, 1'b1);
        @(negedge clk);
        check({nm, "_c1_enable"}, {31'd0, mm_enable}, 32'd0);
        @(negedge clk);
        check({nm, "_c2_ack"}, {30'd0, ack}, idx ? 32'd2 : 32'd1);
        check({nm, "_c2_err"}, {30'd0, err}, idx ? 32'd2 : 32'd1);
        check({nm, "_c2_enable"}, {31'd0, mm_enable}, 32'd0);
        req[idx] = 1'b0;
        @(negedge clk);
        check({nm, "_jobs"}, {16'd0, jobs_done}, {16'd0, jobs_exp});
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got timeout, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        bit ok;
        int cnt;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", {30'd0, ack}, 32'd0);
        check("rst_err", {30'd0, err}, 32'd0);
        check("rst_enable", {31'd0, mm_enable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sel", {31'd0, mm_sel}, 32'd0);
        check("rst_dims", mm_dims, 32'd0);
        check("rst_jobs", {16'd0, jobs_done}, 32'd0);
        reset = 1'b1;

        // Basic job on requester 0, 2-cycle latency, dims changed after grant
        req_dims[0] = 32'h04030504;
        req[0]      = 1'b1;
        push(1'b0, 32'h04030504, 1'b0);
        @(negedge clk);
        check("lat_c1_enable", {31'd0, mm_enable}, 32'd0);
        check("lat_c1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("lat_c2_enable", {31'd0, mm_enable}, 32'd1);
        req_dims[0] = 32'hFFFFFFFF;
        run_for(LONG_DLY);
        wait_ack(1'b0);
        @(negedge clk);
        check("job1_jobs", {16'd0, jobs_done}, 32'd1);
        check("job1_idle", {31'd0, busy}, 32'd0);

        // Rejections and the MAX_DIM boundary
        bad_job(1'b0, 32'h04030506, "bad_axby", 16'd1);
        bad_job(1'b0, 32'h04000504, "bad_zero", 16'd1);
        req_dims[0] = 32'h10010110;
        req[0]      = 1'b1;
        push(1'b0, 32'h10010110, 1'b0);
        wait_en(ok);
        run_for(2);
        wait_ack(1'b0);
        @(negedge clk);
        check("max_dim_jobs", {16'd0, jobs_done}, 32'd2);
        bad_job(1'b1, 32'h04110504, "bad_17", 16'd2);

        // Simultaneous requests, pointer at 0
        req_dims[0] = 32'h02030402;
        req_dims[1] = 32'h05050505;
        req         = 2'b11;
        push(1'b0, 32'h02030402, 1'b0);
        push(1'b1, 32'h05050505, 1'b0);
        wait_en(ok);
        check("rr_first_sel", {31'd0, mm_sel}, 32'd0);
        run_for(3);
        wait_ack(1'b0);
        @(negedge clk);
        check("rr_idle_gap", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("rr_second_busy", {31'd0, busy}, 32'd1);
        check("rr_second_sel", {31'd0, mm_sel}, 32'd1);
        @(negedge clk);
        check("rr_second_enable", {31'd0, mm_enable}, 32'd1);
        run_for(3);
        wait_ack(1'b1);
        @(negedge clk);
        check("rr_jobs", {16'd0, jobs_done}, 32'd4);

        // Stray mm_done in IDLE, req dropped right after grant
        mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
        check("stray_idle", {31'd0, busy}, 32'd0);
        req_dims[0] = 32'h04030504;
        req[0]      = 1'b1;
        push(1'b0, 32'h04030504, 1'b0);
        wait_en(ok);
        req[0] = 1'b0;
        run_for(LONG_DLY);
        wait_ack(1'b0);
        @(negedge clk);
        check("stray_jobs", {16'd0, jobs_done}, 32'd5);

`ifdef MMULT_ARB_TIMEOUT_EN
        // Watchdog: no mm_done
        req_dims[1] = 32'h03030303;
        req[1]      = 1'b1;
        push(1'b1, 32'h03030303, 1'b1);
        wait_en(ok);
        cnt = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mm_enable === 1'b1) cnt++;
            else break;
        end
        check("to_run_cycles", cnt, 32'd8);
        check("to_ack", {30'd0, ack}, 32'd2);
        check("to_err", {30'd0, err}, 32'd2);
        req[1] = 1'b0;
        @(negedge clk);
        check("to_jobs", {16'd0, jobs_done}, 32'd5);
`endif

        // Reset asserted mid-RUN between edges
        req_dims[0] = 32'h04030504;
        req_dims[1] = 32'h05050505;
        req         = 2'b11;
        wait_en(ok);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_enable", {31'd0, mm_enable}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_jobs", {16'd0, jobs_done}, 32'd0);
        check("mid_rst_ack", {30'd0, ack}, 32'd0);
        sbq.delete();
        @(negedge clk);
        reset = 1'b1;
        push(1'b0, 32'h04030504, 1'b0);
        push(1'b1, 32'h05050505, 1'b0);
        @(negedge clk);
        check("regrant_busy", {31'd0, busy}, 32'd1);
        check("regrant_sel", {31'd0, mm_sel}, 32'd0);
        @(negedge clk);
        check("regrant_enable", {31'd0, mm_enable}, 32'd1);
        run_for(3);
        wait_ack(1'b0);
        wait_en(ok);
        check("regrant_second_sel", {31'd0, mm_sel}, 32'd1);
        run_for(3);
        wait_ack(1'b1);
        @(negedge clk);
        check("regrant_jobs", {16'd0, jobs_done}, 32'd2);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
